// File: rtl/sc_trace_monitor_if.sv
// sc_trace_monitor_if
// Purpose : groups the CPU-observation inputs, the reader handshake and the
//           status outputs of the execution-trace monitor.
// Signals : pc/inst/cpu_run    CPU trace sample inputs
//           rd_req/rd_valid    reader pop handshake
//           rd_pc/rd_inst      popped entry
//           count              FIFO occupancy, 0..2**ADDR_W
//           inst_count         captured samples, saturating
//           halted/overflow/seq_err  sticky status flags
//           dbg_state          monitor FSM state (0 idle, 1 capture, 2 halted)
//
// Read handshake: rd_req is a request, not a ready. A cycle with rd_req=1
// while count>0 pops exactly one entry on that rising edge. rd_valid is high
// for the single following cycle and rd_pc/rd_inst carry the popped entry
// during it. rd_req with count==0 is ignored and produces no rd_valid.
// There is no back-pressure on the read data; the reader must take it when
// rd_valid is seen.
interface sc_trace_monitor_if #(
    parameter int ADDR_W = 4
);
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            cpu_run;
    logic            rd_req;
    logic            rd_valid;
    logic [31:0]     rd_pc;
    logic [31:0]     rd_inst;
    logic [ADDR_W:0] count;
    logic [31:0]     inst_count;
    logic            halted;
    logic            overflow;
    logic            seq_err;
    logic [1:0]      dbg_state;

    // Stimulus / reader side.
    modport master (
        output pc, inst, cpu_run, rd_req,
        input  rd_valid, rd_pc, rd_inst, count, inst_count,
               halted, overflow, seq_err, dbg_state
    );

    // Monitor side.
    modport slave (
        input  pc, inst, cpu_run, rd_req,
        output rd_valid, rd_pc, rd_inst, count, inst_count,
               halted, overflow, seq_err, dbg_state
    );
endinterface

// File: rtl/sc_trace_monitor.sv
// sc_trace_monitor
// Purpose : watches the single-cycle CPU's pc/inst every clock while it runs,
//           buffers {pc, inst} samples in a DEPTH-entry FIFO for a reader,
//           counts samples, detects a self-loop halt and flags misaligned PCs.
// Ports   : clock  system clock (same as the CPU), rising edge
//           reset  asynchronous, active-high; clears all state
//           bus    sc_trace_monitor_if.slave (sample inputs, read handshake,
//                  status outputs, FSM debug state)
module sc_trace_monitor #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HALT_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    sc_trace_monitor_if.slave   bus
);

    localparam int              REP_W    = $clog2(HALT_CYCLES + 1);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [REP_W-1:0] HALT_REP = HALT_CYCLES[REP_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t            r_state;
    logic [63:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_inst_count;
    logic              r_halted;
    logic              r_overflow;
    logic              r_seq_err;
    logic              r_rd_valid;
    logic [31:0]       r_rd_pc;
    logic [31:0]       r_rd_inst;
    logic [31:0]       r_prev_pc;
    logic              r_prev_valid;
    logic [REP_W-1:0]  r_rep_cnt;

    logic              w_sample;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_pc_match;
    logic [REP_W-1:0]  w_rep_next;
    logic              w_halt;

    // A sample is taken only from CAPTURE; the IDLE->CAPTURE edge itself
    // takes nothing because the FSM is still in IDLE on that edge.
    assign w_sample   = (r_state == ST_CAPTURE) && bus.cpu_run;
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = bus.rd_req && (r_count != '0);
    // When full, a same-cycle pop frees the slot, so the write still lands.
    assign w_wr       = w_sample && (!w_full || bus.rd_req);
    assign w_pc_match = r_prev_valid && (bus.pc == r_prev_pc);
    assign w_rep_next = w_pc_match ? (r_rep_cnt + REP_W'(1)) : '0;
    assign w_halt     = w_sample && (w_rep_next == HALT_REP);

    // Storage has no reset: contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {bus.pc, bus.inst};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_inst_count <= '0;
            r_halted     <= 1'b0;
            r_overflow   <= 1'b0;
            r_seq_err    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_pc      <= '0;
            r_rd_inst    <= '0;
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            // Read side runs in every FSM state.
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_pc   <= r_mem[r_rd_ptr][63:32];
                r_rd_inst <= r_mem[r_rd_ptr][31:0];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Sample bookkeeping: counted even when the FIFO drops it.
            if (w_sample) begin
                if (r_inst_count != 32'hFFFF_FFFF) begin
                    r_inst_count <= r_inst_count + 1'b1;
                end
                if (bus.pc[1:0] != 2'b00) begin
                    r_seq_err <= 1'b1;
                end
                if (w_full && !bus.rd_req) begin
                    r_overflow <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_run) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.cpu_run) begin
                        // New episode starts with no reference PC.
                        r_state      <= ST_IDLE;
                        r_rep_cnt    <= '0;
                        r_prev_valid <= 1'b0;
                    end else begin
                        r_prev_pc    <= bus.pc;
                        r_prev_valid <= 1'b1;
                        r_rep_cnt    <= w_rep_next;
                        if (w_halt) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_pc      = r_rd_pc;
    assign bus.rd_inst    = r_rd_inst;
    assign bus.count      = r_count;
    assign bus.inst_count = r_inst_count;
    assign bus.halted     = r_halted;
    assign bus.overflow   = r_overflow;
    assign bus.seq_err    = r_seq_err;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sc_trace_monitor.sv
// tb_sc_trace_monitor
// Purpose : directed and randomized stimulus for sc_trace_monitor, checked
//           every cycle against a queue-based reference of the trace monitor.
module tb_sc_trace_monitor;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int HALT_CYCLES = 3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sc_trace_monitor_if #(.ADDR_W(ADDR_W)) bus();

    sc_trace_monitor #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [63:0] exp_q[$];
    bit          m_active;
    bit          m_halted;
    bit          m_prev_valid;
    logic [31:0] m_prev_pc;
    int          m_rep;
    logic [31:0] m_ic;
    bit          m_ovf;
    bit          m_seq;
    bit          m_rd_valid;
    logic [31:0] m_rd_pc;
    logic [31:0] m_rd_inst;

    task automatic model_reset();
        exp_q.delete();
        m_active     = 0;
        m_halted     = 0;
        m_prev_valid = 0;
        m_prev_pc    = '0;
        m_rep        = 0;
        m_ic         = '0;
        m_ovf        = 0;
        m_seq        = 0;
        m_rd_valid   = 0;
        m_rd_pc      = '0;
        m_rd_inst    = '0;
    endtask

    // Effect of one rising edge given the inputs held during the cycle.
    task automatic model_step(input bit run, input logic [31:0] pc,
                              input logic [31:0] inst, input bit rd);
        logic [63:0] item;
        bit full;
        full = (exp_q.size() == DEPTH);
        if (rd && exp_q.size() > 0) begin
            item       = exp_q.pop_front();
            m_rd_valid = 1;
            m_rd_pc    = item[63:32];
            m_rd_inst  = item[31:0];
        end else begin
            m_rd_valid = 0;
        end
        if (m_active && !m_halted && run) begin
            if (m_ic != 32'hFFFF_FFFF) m_ic = m_ic + 1;
            if (pc[1:0] != 2'b00) m_seq = 1;
            if (full && !rd) m_ovf = 1;
            else exp_q.push_back({pc, inst});
            if (m_prev_valid && pc == m_prev_pc) m_rep = m_rep + 1;
            else m_rep = 0;
            m_prev_pc    = pc;
            m_prev_valid = 1;
            if (m_rep == HALT_CYCLES) m_halted = 1;
        end else if (!m_halted) begin
            if (m_active && !run) begin
                m_active     = 0;
                m_prev_valid = 0;
                m_rep        = 0;
            end else if (!m_active && run) begin
                m_active = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":rd_valid"},   64'(bus.rd_valid),   64'(m_rd_valid));
        chk({ctx, ":rd_pc"},      64'(bus.rd_pc),      64'(m_rd_pc));
        chk({ctx, ":rd_inst"},    64'(bus.rd_inst),    64'(m_rd_inst));
        chk({ctx, ":count"},      64'(bus.count),      64'(exp_q.size()));
        chk({ctx, ":inst_count"}, 64'(bus.inst_count), 64'(m_ic));
        chk({ctx, ":halted"},     64'(bus.halted),     64'(m_halted));
        chk({ctx, ":overflow"},   64'(bus.overflow),   64'(m_ovf));
        chk({ctx, ":seq_err"},    64'(bus.seq_err),    64'(m_seq));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input string ctx, input bit run, input logic [31:0] pc,
                         input logic [31:0] inst, input bit rd);
        bus.cpu_run = run;
        bus.pc      = pc;
        bus.inst    = inst;
        bus.rd_req  = rd;
        model_step(run, pc, inst, rd);
        @(posedge clock);
        #1;
        check_outputs(ctx);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.cpu_run = 1'b0;
        bus.rd_req  = 1'b0;
        bus.pc      = '0;
        bus.inst    = '0;
        @(posedge clock);
        #1;
        model_reset();
        check_outputs("reset_held");
        reset = 1'b0;
    endtask

    // Reset asserted and released between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs("reset_pulse");
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] base;
        logic [31:0] pc;
        logic [31:0] last_pc;
        bit run;
        bit rd;
        logic [31:0] halt_pcs [7];

        model_reset();
        bus.cpu_run = 1'b0;
        bus.rd_req  = 1'b0;
        bus.pc      = '0;
        bus.inst    = '0;

        // Reset / idle
        @(posedge clock);
        do_reset();
        for (int i = 0; i < 5; i++) cycle("idle", 0, $urandom, $urandom, 0);
        chk("idle_count", 64'(bus.count), 64'd0);

        // Basic capture: transition edge takes nothing, then four samples
        cycle("basic_enter", 1, 32'hFFFF_FFF0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cycle("basic_cap", 1, 32'(4 * i), 32'hA0 + 32'(i), 0);
        chk("basic_count4", 64'(bus.count), 64'd4);
        cycle("basic_exit", 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("basic_pop", 0, 32'h0, 32'h0, 1);
            chk("basic_pop_pc", 64'(bus.rd_pc), 64'(4 * i));
            chk("basic_pop_inst", 64'(bus.rd_inst), 64'(32'hA0 + 32'(i)));
        end
        cycle("basic_after", 0, 32'h0, 32'h0, 0);
        chk("basic_count0", 64'(bus.count), 64'd0);
        chk("basic_ic4", 64'(bus.inst_count), 64'd4);

        // Halt on self-loop
        do_reset();
        halt_pcs = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8};
        cycle("halt_enter", 1, 32'h0, 32'h0, 0);
        for (int i = 0; i < 6; i++) cycle("halt_cap", 1, halt_pcs[i], $urandom, 0);
        chk("halt_flag", 64'(bus.halted), 64'd1);
        chk("halt_ic6", 64'(bus.inst_count), 64'd6);
        chk("halt_count6", 64'(bus.count), 64'd6);
        cycle("halt_7th", 1, halt_pcs[6], $urandom, 0);
        chk("halt_7th_count", 64'(bus.count), 64'd6);
        chk("halt_7th_ic", 64'(bus.inst_count), 64'd6);
        cycle("halt_pop", 1, 32'h0, 32'h0, 1);
        chk("halt_pop_count5", 64'(bus.count), 64'd5);

        // Reset mid-operation, then restart from IDLE
        pulse_reset();
        chk("rst_halted0", 64'(bus.halted), 64'd0);
        cycle("restart_enter", 1, 32'h100, 32'h1, 0);
        cycle("restart_cap", 1, 32'h104, 32'h2, 0);
        chk("restart_count1", 64'(bus.count), 64'd1);

        // Overflow and wrap
        do_reset();
        base = $urandom & 32'hFFFF_0000;
        cycle("ovf_enter", 1, 32'h0, 32'h0, 0);
        for (int i = 0; i < 18; i++) cycle("ovf_cap", 1, base + 32'(4 * i), $urandom, 0);
        chk("ovf_count16", 64'(bus.count), 64'd16);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        chk("ovf_ic18", 64'(bus.inst_count), 64'd18);
        cycle("ovf_exit", 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle("ovf_pop", 0, 32'h0, 32'h0, 1);
            chk("ovf_pop_pc", 64'(bus.rd_pc), 64'(base + 32'(4 * i)));
        end
        base = base + 32'h1000;
        cycle("wrap_enter", 1, 32'h0, 32'h0, 1);
        for (int i = 0; i < 20; i++) cycle("wrap_cap", 1, base + 32'(4 * i), $urandom, 1);
        cycle("wrap_drain", 0, 32'h0, 32'h0, 1);
        chk("wrap_last_pc", 64'(bus.rd_pc), 64'(base + 32'(4 * 19)));
        chk("wrap_count0", 64'(bus.count), 64'd0);

        // Edge cases: misaligned pc, full write+pop, empty read
        do_reset();
        base = $urandom & 32'hFFFF_0000;
        cycle("edge_enter", 1, 32'h0, 32'h0, 0);
        for (int i = 0; i < 16; i++)
            cycle("edge_fill", 1, (i == 3) ? 32'h6 : base + 32'h100 + 32'(4 * i), $urandom, 0);
        chk("edge_seq_err", 64'(bus.seq_err), 64'd1);
        cycle("edge_full_wp", 1, base + 32'h800, $urandom, 1);
        chk("edge_full_count", 64'(bus.count), 64'd16);
        chk("edge_full_ovf", 64'(bus.overflow), 64'd0);
        cycle("edge_exit", 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 16; i++) cycle("edge_drain", 0, 32'h0, 32'h0, 1);
        cycle("edge_empty_rd", 0, 32'h0, 32'h0, 1);
        chk("edge_empty_rdv", 64'(bus.rd_valid), 64'd0);

        // Randomized phase
        do_reset();
        last_pc = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                run = ($urandom_range(0, 9) < 8);
                rd  = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 2) == 0) pc = last_pc;
                else if ($urandom_range(0, 15) == 0) pc = $urandom;
                else pc = $urandom & 32'hFFFF_FFFC;
                last_pc = pc;
                cycle("rand", run, pc, $urandom, rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_trace_monitor.md
# sc_trace_monitor

Synthesizable execution-trace monitor for the single-cycle computer. It observes the CPU's `pc`/`inst` outputs every clock and buffers the samples in a DEPTH-entry FIFO for a downstream reader. It also counts executed instructions, detects a self-loop halt, and flags misaligned PCs. It attaches beside `sc_computer` on the same clock, both in simulation and on the board, and is the observing end of the stimulus that drives reset and clock into the CPU.

## Interface
Parameters:
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- ADDR_W, 4, log2(DEPTH)
- HALT_CYCLES, 3, consecutive repeated-PC samples that declare halt; ≥1

Ports:
- clock  in  1  system clock; same clock as the CPU; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pc  in  32  CPU program counter
- inst  in  32  CPU current instruction
- cpu_run  in  1  high while the CPU is out of reset and executing
- rd_req  in  1  reader pop request
- rd_valid  out  1  one-cycle pulse; rd_pc/rd_inst hold a popped entry
- rd_pc  out  32  popped PC
- rd_inst  out  32  popped instruction
- count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- inst_count  out  32  samples captured; saturates at 32'hFFFF_FFFF
- halted  out  1  sticky; self-loop detected
- overflow  out  1  sticky; at least one sample dropped because the FIFO was full
- seq_err  out  1  sticky; a captured pc had pc[1:0] != 0

## Operation
- FSM states: IDLE, CAPTURE, HALTED. Reset puts the FSM in IDLE.
- IDLE → CAPTURE when cpu_run=1. No sample is taken on the transition edge.
- CAPTURE → IDLE when cpu_run=0. No sample is taken that edge.
- CAPTURE → HALTED on the halt condition defined below.
- HALTED is left only by reset. cpu_run is ignored in HALTED.
- CAPTURE sample, taken every edge with cpu_run=1:
  - Write {pc, inst} at wr_ptr.
  - Increment inst_count, saturating.
  - If pc[1:0] != 0, set seq_err.
- Full: if count==DEPTH and rd_req=0, the write is dropped and overflow is set. inst_count still increments.
- Full with rd_req=1 in the same cycle: the write is accepted and count stays at DEPTH.
- Halt detection:
  - prev_pc holds the last sampled pc and is valid after the first sample of a CAPTURE episode.
  - If a sample equals prev_pc, rep_cnt increments; otherwise rep_cnt clears to 0.
  - When rep_cnt reaches HALT_CYCLES on that sample, the FSM enters HALTED and halted=1.
  - The halting sample is itself written and counted.
- Leaving CAPTURE for IDLE clears rep_cnt and invalidates prev_pc.
- Read side:
  - rd_req with count>0 pops the entry at rd_ptr. rd_pc/rd_inst are registered and rd_valid=1 for the next cycle only.
  - rd_req with count==0 is ignored; rd_valid stays 0 and nothing else changes.
  - Reads are serviced in every FSM state, including IDLE and HALTED.
- Simultaneous write and pop: both take effect and count is unchanged.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- count is an explicit register: +1 on write only, −1 on pop only.

## Timing
- Reset values:
  - rd_valid=0, rd_pc=0, rd_inst=0
  - count=0, inst_count=0
  - halted=0, overflow=0, seq_err=0
  - FSM=IDLE, wr_ptr=0, rd_ptr=0, rep_cnt=0
- Reset is asynchronous. Asserting it mid-capture or mid-read clears all registers immediately. FIFO contents are don't-care afterwards.
- Sample latency: a sample written at edge k is reflected in count after edge k and can be popped by rd_req in cycle k+1. Its rd_valid appears after edge k+1.
- Pop throughput: one entry per cycle with rd_req held high. rd_valid follows rd_req by one cycle.
- halted rises on the edge that takes the halting sample.
- Status registers (count, inst_count, halted, overflow, seq_err) update on the same edge as the event that causes them.

## Test plan
- **Reset/idle:** hold reset=1, then release with cpu_run=0 for 5 cycles → all outputs 0, count stays 0.
- **Basic capture:** cpu_run=1; pc=0,4,8,12 with inst=A0..A3; then pop 4 times → rd_pc=0,4,8,12 in order with matching inst, rd_valid=1 for exactly 4 cycles, count ends at 0, inst_count=4.
- **Halt:** HALT_CYCLES=3, pc sequence 0,4,8,8,8,8,8 → halted=1 after the 6th sample, inst_count=6, count=6, and the 7th sample is not captured.
- **Overflow and wrap:**
  - DEPTH=16; capture 18 distinct PCs with no reads → count=16, overflow=1, inst_count=18.
  - Pop 16 → PCs 1..16 of the sequence.
  - Capture 20 more while popping every cycle → no new overflow, order preserved across the pointer wrap.
- **Edge cases:** a capture with pc=32'h6 sets seq_err=1. rd_req with count==0 gives no rd_valid. A simultaneous write+pop at count==DEPTH leaves count=16 and overflow unchanged.
- **Reset mid-operation:** with count=5 and halted=1, pulse reset for a partial cycle → all outputs 0 immediately. cpu_run=1 then restarts capture from IDLE.
